fifo_wr_arbiter: RTL and testbench

- Shares the single write port of one fifo_ctrl-based buffer among N packet producers, for example the parallel compressor lanes in Stage1.
- Grants are round-robin and packet-locked: once a requester wins, it keeps the FIFO write port until its last beat, so packets never interleave.
- The block drives the FIFO wr strobe and write data, and back-pressures requesters from the FIFO full flag.
- It also keeps a saturating count of words written.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   state_e   : arbiter FSM state (ARB = pick a winner, LOCK = owner streams).
//   idx_width : width of a requester index, $clog2(n) but never below 1.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : fifo_arb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts one above the previous
// winner and wraps modulo N, so the last winner has the lowest priority.
// Ports:
//   req_i        in  N   request vector
//   last_grant_i in  IW  index of the previous winner
//   grant_o      out N   one-hot grant (all zero when nothing requests)
//   grant_idx_o  out IW  index of the granted requester (0 when none)
//   any_req_o    out 1   at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_req_o
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    idx         = 0;
    // Offsets 1..N visit every index once, ending on last_grant itself, so a
    // lone requester that just won can win again.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_i) + k) % N;
      if (!any_req_o && req_i[IW'(idx)]) begin
        any_req_o          = 1'b1;
        grant_o[IW'(idx)]  = 1'b1;
        grant_idx_o        = IW'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one FIFO write port among N packet producers. Grants are round-robin
// and held for a whole packet, so packets from different producers never
// interleave in the FIFO. Back-pressure comes from the FIFO full flag. A
// saturating counter tracks the number of words written.
// Ports:
//   clk            in  1             rising-edge clock
//   reset          in  1             asynchronous reset, active low
//   req_valid      in  N             per-requester word valid
//   req_last       in  N             per-requester last word of packet
//   req_data       in  N*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      out N             per-requester accept
//   fifo_full      in  1             FIFO full flag
//   fifo_wr        out 1             FIFO write strobe
//   fifo_wdata     out DATA_WIDTH    FIFO write data
//   grant_id       out $clog2(N)     current owner index
//   busy           out 1             high while a packet owns the port
//   words_written  out CNT_WIDTH     saturating count of FIFO writes
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            req_valid,
  input  logic [N-1:0]            req_last,
  input  logic [N*DATA_WIDTH-1:0] req_data,
  output logic [N-1:0]            req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [DATA_WIDTH-1:0]   fifo_wdata,
  output logic [idx_width(N)-1:0] grant_id,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    words_written
);

  localparam int IW = idx_width(N);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [N-1:0]           owner_oh_q, owner_oh_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [N-1:0]           arb_grant;
  logic [IW-1:0]          arb_idx;
  logic                   arb_any;
  logic [DATA_WIDTH-1:0]  lane_data [N];

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr_arbiter (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx),
    .any_req_o    (arb_any)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Unqualified by fifo_wr: the FIFO ignores wdata when no write is strobed.
  assign fifo_wdata = lane_data[owner_q];

  // The owner is also kept one-hot so ready/valid/last qualification is a
  // plain AND with no index decode on the handshake path.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    owner_oh_d   = owner_oh_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    fifo_wr      = 1'b0;

    unique case (state_q)
      ARB: begin
        if (arb_any) begin
          owner_d      = arb_idx;
          owner_oh_d   = arb_grant;
          last_grant_d = arb_idx;
          state_d      = LOCK;
        end
      end
      LOCK: begin
        req_ready = owner_oh_q & {N{~fifo_full}};
        fifo_wr   = (|(req_valid & owner_oh_q)) & ~fifo_full;
        // An idle owner or a full FIFO simply holds the lock.
        if (fifo_wr && (|(req_last & owner_oh_q))) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign cnt_d = (fifo_wr && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      owner_q      <= '0;
      owner_oh_q   <= N'(1);
      last_grant_q <= IW'(N - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      owner_oh_q   <= owner_oh_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign grant_id      = owner_q;
  assign busy          = (state_q == LOCK);
  assign words_written = cnt_q;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Producers are fed from per-requester word queues; every word issued is also
// pushed to a per-requester expected queue. A negedge monitor runs a
// packet-level reference (round-robin pick over valid requesters, owner held
// until its last word, saturating write count) and pops/compares whenever a
// write is due.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int IW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_wdata;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic [CW-1:0]     words_written;

  fifo_wr_arbiter #(
    .N          (N),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_wr       (fifo_wr),
    .fifo_wdata    (fifo_wdata),
    .grant_id      (grant_id),
    .busy          (busy),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Items are {last, data}.
  logic [DW:0]   prod_q [N][$];
  logic [DW:0]   exp_q  [N][$];
  int            seq    [N];
  logic [N-1:0]  en;
  logic [N-1:0]  fire = '0;
  int            full_pct;
  int            force_full;

  int            errors = 0;
  int            checks = 0;

  // Reference state.
  logic          m_busy;
  int            m_owner;
  int            m_last;
  int            m_cnt;

  int            grant_log [$];
  logic [DW-1:0] wlog [$];
  int            nwrites = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic load(input int r, input int len);
    logic [DW:0] item;
    for (int w = 0; w < len; w++) begin
      item = {(w == len - 1), 8'(r), 24'(seq[r])};
      seq[r]++;
      prod_q[r].push_back(item);
      exp_q[r].push_back(item);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (prod_q[i].size() > 0 && en[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = prod_q[i][0][DW];
        req_data[i*DW +: DW]  = prod_q[i][0][DW-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW]  = $urandom;
      end
    end
    if (force_full > 0) begin
      fifo_full = 1'b1;
      force_full--;
    end else begin
      fifo_full = ($urandom_range(0, 99) < full_pct);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (fire[i]) void'(prod_q[i].pop_front());
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    drive();
    repeat (2) tick();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive();
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < N; i++) p += prod_q[i].size();
    return p;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    en       = '1;
    full_pct = 0;
    while (pending() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain within budget", 64'(pending()), 64'd0);
    repeat (2) tick();
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic        exp_wr;
    logic [N-1:0] exp_rdy;
    logic [DW:0] e;
    int          w;
    fire = '0;
    if (!reset) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = N - 1;
      m_cnt   = 0;
      check("rst fifo_wr", 64'(fifo_wr), 64'd0);
      check("rst req_ready", 64'(req_ready), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst grant_id", 64'(grant_id), 64'd0);
      check("rst words_written", 64'(words_written), 64'd0);
    end else begin
      check("words_written", 64'(words_written), 64'(m_cnt));
      check("grant_id", 64'(grant_id), 64'(m_owner));
      check("busy", 64'(busy), 64'(m_busy));
      if (!m_busy) begin
        check("arb fifo_wr", 64'(fifo_wr), 64'd0);
        check("arb req_ready", 64'(req_ready), 64'd0);
        w = rr_pick(req_valid, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_busy  = 1'b1;
          grant_log.push_back(w);
        end
      end else begin
        exp_wr  = req_valid[m_owner] && !fifo_full;
        exp_rdy = fifo_full ? '0 : (N'(1) << m_owner);
        check("lock fifo_wr", 64'(fifo_wr), 64'(exp_wr));
        check("lock req_ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_wr) begin
          if (exp_q[m_owner].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: write from requester %0d with nothing expected (t=%0t)", m_owner, $time);
          end else begin
            e = exp_q[m_owner].pop_front();
            check("fifo_wdata", 64'(fifo_wdata), 64'(e[DW-1:0]));
            if (m_cnt < CNT_MAX) m_cnt++;
            if (e[DW]) m_busy = 1'b0;
          end
        end
      end
      if (fifo_wr) begin
        wlog.push_back(fifo_wdata);
        nwrites++;
      end
      fire = req_valid & req_ready;
    end
  end

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int n;
    int base;

    reset      = 1'b0;
    en         = '1;
    full_pct   = 0;
    force_full = 0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    fifo_full  = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Reset held with every requester valid, then round-robin of single words.
    for (int r = 0; r < N; r++) begin
      for (int p = 0; p < 3; p++) load(r, 1);
    end
    drive();
    repeat (3) tick();
    grant_log.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive();
    repeat (10) tick();
    @(negedge clk);
    check("rr words_written after 10", 64'(words_written), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check("rr grant order", 64'(grant_log[k]), 64'(rr_exp[k]));
    end
    drain(200);

    // Packet lock: requester 1 sends three words while requester 2 waits.
    do_reset();
    wlog.delete();
    load(1, 3);
    load(2, 2);
    drain(100);
    check("lock write count", 64'(wlog.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check("lock write owner", 64'(wlog[k][31:24]), (k < 3) ? 64'd1 : 64'd2);
    end

    // Back-pressure: three full cycles after the second word.
    do_reset();
    wlog.delete();
    nwrites = 0;
    load(0, 4);
    n = 0;
    while (nwrites < 2 && n < 50) begin
      tick();
      n++;
    end
    check("bp reached 2nd word", 64'(nwrites >= 2), 64'd1);
    force_full = 3;
    drive();
    drain(100);
    check("bp write count", 64'(wlog.size()), 64'd4);
    base = int'(wlog[0][23:0]);
    for (int k = 0; k < 4; k++) begin
      check("bp word order", 64'(wlog[k]), 64'({8'd0, 24'(base + k)}));
    end

    // Saturation: 20 single-word writes on a 4-bit counter.
    do_reset();
    nwrites = 0;
    for (int p = 0; p < 20; p++) load(3, 1);
    drain(200);
    @(negedge clk);
    check("sat writes issued", 64'(nwrites), 64'd20);
    check("sat words_written", 64'(words_written), 64'(CNT_MAX));

    // Reset after the 2nd of 4 words.
    do_reset();
    nwrites = 0;
    load(0, 4);
    load(1, 1);
    load(2, 1);
    en = 4'b0001;
    drive();
    n = 0;
    while (nwrites < 2 && n < 50) begin
      tick();
      n++;
    end
    check("mid rst reached 2nd word", 64'(nwrites >= 2), 64'd1);
    reset = 1'b0;
    prod_q[0].delete();
    exp_q[0].delete();
    drive();
    @(negedge clk);
    check("mid rst fifo_wr", 64'(fifo_wr), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    repeat (2) tick();
    grant_log.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    en    = '1;
    drive();
    drain(100);
    check("mid rst grant count", 64'(grant_log.size()), 64'd2);
    check("mid rst next grant", 64'(grant_log[0]), 64'd1);

    // Randomized traffic with drops of valid and random full.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N; r++) begin
        if (prod_q[r].size() < 3 && $urandom_range(0, 3) == 0) load(r, $urandom_range(1, 4));
        en[r] = ($urandom_range(0, 3) != 0);
      end
      full_pct = 20;
      tick();
    end
    drain(3000);

    for (int r = 0; r < N; r++) begin
      check("scoreboard empty", 64'(exp_q[r].size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
